// File: rtl/xoodyak_pkg.sv
// Shared definitions for the Xoodyak hash datapath: state width, default
// permutation timeout, core port widths and the arbiter FSM encoding.
package xoodyak_pkg;

  localparam int STATE_W      = 384;
  localparam int TIMEOUT_DEF  = 64;

  // Core port widths, shared by the hash engines, the arbiter and the core.
  localparam int CORE_STATE_W = STATE_W;
  localparam int CORE_CTRL_W  = 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_RESPOND = 2'd3
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: returns the first set candidate bit
// found scanning upward from ptr, wrapping modulo NUM_REQ.
module rr_pick #(
  parameter int NUM_REQ = 2
)(
  input  logic [NUM_REQ-1:0]         candidates,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic                       valid,
  output logic [$clog2(NUM_REQ)-1:0] index
);

  localparam int IW = $clog2(NUM_REQ);

  logic [IW:0] w_pos;

  // Scan offsets from farthest to nearest so the nearest hit is kept last.
  always_comb begin
    valid = 1'b0;
    index = '0;
    w_pos = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      w_pos = {1'b0, ptr} + (IW+1)'(i);
      if (w_pos >= (IW+1)'(NUM_REQ)) begin
        w_pos = w_pos - (IW+1)'(NUM_REQ);
      end
      if (candidates[w_pos[IW-1:0]]) begin
        valid = 1'b1;
        index = w_pos[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/xoodoo_arbiter.sv
// Shares one iterative Xoodoo core between NUM_REQ requesters.
// Handshake: a requester holds req_valid (and a stable req_state) until it
// sees its one-cycle req_done or req_error pulse; the core is started by a
// single core_enable pulse and answers with a single core_complete pulse,
// core_state_in being valid only in that cycle.
module xoodoo_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int STATE_W = xoodyak_pkg::STATE_W,
  parameter int TIMEOUT = xoodyak_pkg::TIMEOUT_DEF
)(
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*STATE_W-1:0]    req_state,
  output logic [NUM_REQ-1:0]            req_done,
  output logic [NUM_REQ-1:0]            req_error,
  output logic [STATE_W-1:0]            rsp_state,
  output logic                          core_enable,
  output logic [STATE_W-1:0]            core_state_out,
  input  logic                          core_complete,
  input  logic [STATE_W-1:0]            core_state_in,
  output logic                          busy,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic [1:0]                    dbg_state
);

  import xoodyak_pkg::*;

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT + 1);

  arb_state_t          r_state;
  arb_state_t          w_next;
  logic [IW-1:0]       r_grant;
  logic [IW-1:0]       r_ptr;
  logic [NUM_REQ-1:0]  r_mask;
  logic [CW-1:0]       r_cnt;
  logic                r_err;
  logic [STATE_W-1:0]  r_rsp;
  logic [STATE_W-1:0]  r_core_state;

  logic [NUM_REQ-1:0]  w_cand;
  logic                w_pick_valid;
  logic [IW-1:0]       w_pick_idx;
  logic                w_timeout;
  logic [NUM_REQ-1:0]  w_grant_1h;

  // The requester served last is masked for exactly one IDLE cycle.
  assign w_cand     = req_valid & ~r_mask;
  assign w_timeout  = (r_cnt == CW'(TIMEOUT - 1));
  assign w_grant_1h = NUM_REQ'(1) << r_grant;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .candidates (w_cand),
    .ptr        (r_ptr),
    .valid      (w_pick_valid),
    .index      (w_pick_idx)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic; completion beats timeout when both land together.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    if (w_pick_valid) w_next = ST_ISSUE;
      ST_ISSUE:   w_next = ST_WAIT;
      ST_WAIT:    if (core_complete || w_timeout) w_next = ST_RESPOND;
      ST_RESPOND: w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  // Grant capture, timeout counting, response capture and pointer update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_grant      <= '0;
      r_ptr        <= '0;
      r_mask       <= '0;
      r_cnt        <= '0;
      r_err        <= 1'b0;
      r_rsp        <= '0;
      r_core_state <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_mask <= '0;
          if (w_pick_valid) begin
            r_grant      <= w_pick_idx;
            r_core_state <= req_state[int'(w_pick_idx)*STATE_W +: STATE_W];
            r_err        <= 1'b0;
          end
        end
        ST_ISSUE: begin
          r_cnt <= '0;
        end
        ST_WAIT: begin
          r_cnt <= r_cnt + 1'b1;
          if (core_complete) begin
            r_rsp <= core_state_in;
            r_err <= 1'b0;
          end else if (w_timeout) begin
            r_err <= 1'b1;
          end
        end
        ST_RESPOND: begin
          r_ptr  <= (int'(r_grant) == NUM_REQ - 1) ? '0 : r_grant + 1'b1;
          r_mask <= w_grant_1h;
        end
        default: ;
      endcase
    end
  end

  // Outputs decode directly from registers, so reset clears them at once.
  assign core_enable    = (r_state == ST_ISSUE);
  assign busy           = (r_state != ST_IDLE);
  assign req_done       = (r_state == ST_RESPOND && !r_err) ? w_grant_1h : '0;
  assign req_error      = (r_state == ST_RESPOND &&  r_err) ? w_grant_1h : '0;
  assign rsp_state      = r_rsp;
  assign core_state_out = r_core_state;
  assign grant_id       = r_grant;
  assign dbg_state      = r_state;

endmodule
